zion_shared_reg_arbiter: RTL and testbench
==========================================

// Module: zion_shared_reg_arbiter
// PURPOSE
//   Round-robin write arbiter for one shared register (oDat) with clear and enable semantics.
//   NUM_REQ requesters each offer a write (iReq) or a clear (iClr).
//   A requester may lock ownership for an atomic burst (iLock), bounded by LOCK_MAX cycles.
//   Sits in front of a shared control/status register; the register is internal and registered.
// PARAMETERS
//   NUM_REQ   4    number of requesters, must be >= 2
//   WIDTH     32   register / data width
//   INI_DATA  '0   reset value and clear value of oDat
//   LOCK_MAX  8    max cycles a lock is held; 0 disables locking; must be < 2**16
// PORTS
//   clk     in   1                clock, all state on posedge
//   rst     in   1                synchronous reset, active high
//   iReq    in   NUM_REQ          per-requester write request
//   iClr    in   NUM_REQ          per-requester clear request
//   iLock   in   NUM_REQ          per-requester lock request, sampled on the granted cycle
//   iDat    in   NUM_REQ*WIDTH    write data; requester i uses bits [i*WIDTH +: WIDTH]
//   oAck    out  NUM_REQ          one-hot combinational grant; the request is consumed this cycle
//   oDat    out  WIDTH            shared register value
//   oUpd    out  1                pulse: oDat was updated at the last edge
//   oOwner  out  $clog2(NUM_REQ)  index of the requester that made the last update
//   oLocked out  1                FSM is in LOCKED
// BEHAVIOUR
//   Reset (rst=1 at posedge): oDat=INI_DATA, oUpd=0, oOwner=0, ptr=0, state=IDLE, cnt=0.
//     oAck is forced to 0 in any cycle where rst=1, so no request is consumed.
//   cand[i] = iReq[i] | iClr[i].
//   IDLE state:
//     - Winner w = first set cand starting at index ptr, ascending and wrapping.
//     - oAck[w] = 1 in the same cycle.
//     - Next edge: oDat <= iClr[w] ? INI_DATA : iDat[w]; oUpd <= 1; oOwner <= w.
//     - If LOCK_MAX > 0 and iLock[w] = 1: go to LOCKED with lock owner w, cnt = 1, ptr unchanged.
//     - Otherwise: ptr <= (w+1) mod NUM_REQ.
//     - No candidate: oAck = 0, oUpd <= 0, oDat and ptr hold.
//   LOCKED state (oLocked=1):
//     - Only the lock owner o is eligible; oAck[o] = cand[o]. Other requesters stall with oAck = 0.
//     - The update rule is the same as IDLE. oUpd is 1 only on cycles where o was acked.
//     - cnt increments every LOCKED cycle, whether or not o requests.
//     - Exit to IDLE when iLock[o] = 0 or cnt == LOCK_MAX; on exit, ptr <= (o+1) mod NUM_REQ.
//     - The final ack in the exit cycle is still honoured.
//   Clear and write from the same requester in the same cycle: the clear wins (oDat <= INI_DATA).
//   Latency: ack to oDat/oUpd is 1 cycle. Back-to-back grants are allowed every cycle; no bubbles.
//   Fairness: in IDLE, a continuously requesting requester waits at most NUM_REQ-1 grants.
//     With locks, the bound is (NUM_REQ-1)*LOCK_MAX cycles.
//   Reset while LOCKED: return to IDLE and ptr = 0 at the same edge; the lock is abandoned.
//   Elaboration checks ($error): NUM_REQ < 2; LOCK_MAX >= 2**16; WIDTH < 1.
// TESTING
//   1. Reset: rst=1 for 2 cycles with all iReq=1 -> oAck=0, oDat=INI_DATA, oUpd=0, oOwner=0.
//   2. Round-robin:
//      - Stimulus: iReq=4'b1111 held, iDat[i]=i+10.
//      - Required: oAck = 0001,0010,0100,1000,0001 in order; oDat = 10,11,12,13,10 one cycle later each.
//   3. Clear priority:
//      - Stimulus: oDat=0x55; req1 with iReq=1, iClr=1, iDat=0xAA.
//      - Required: oDat=INI_DATA; oOwner=1; oUpd=1.
//   4. Lock with LOCK_MAX=3:
//      - Stimulus: req2 locks; req0 and req2 request continuously.
//      - Required: req2 is granted 3 consecutive cycles, then exit; next grant goes to req3 if requesting, else req0.
//   5. Early unlock and reset:
//      - Stimulus: req1 locks, drops iLock after 1 cycle.
//      - Required: IDLE next cycle, ptr=2.
//      - Stimulus: repeat the lock and assert rst mid-lock.
//      - Required: oLocked=0 and grant order restarts at req0.
//   6. LOCK_MAX=0: iLock=all ones -> oLocked stays 0; pure round-robin as in test 2.

Source files
------------

// File: rtl/zion_shared_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// zion_shared_reg_arbiter_if
//   Bundle of request/grant/register signals between NUM_REQ requesters and
//   the shared register arbiter.
//
//   Handshake: iReq[i] | iClr[i] acts as "valid" for requester i and oAck[i]
//   acts as "ready". A request is consumed in exactly the cycle where it is
//   asserted and oAck[i] is high; the requester must hold iReq/iClr/iDat/iLock
//   stable until that cycle and may change them freely afterwards. oAck is
//   combinational and at most one bit is set.
//
//   Ports (by modport):
//     master : drives iReq, iClr, iLock, iDat; observes oAck, oDat, oUpd,
//              oOwner, oLocked
//     slave  : the arbiter side (the reverse directions)
// -----------------------------------------------------------------------------
interface zion_shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       iReq;
    logic [NUM_REQ-1:0]       iClr;
    logic [NUM_REQ-1:0]       iLock;
    logic [NUM_REQ*WIDTH-1:0] iDat;
    logic [NUM_REQ-1:0]       oAck;
    logic [WIDTH-1:0]         oDat;
    logic                     oUpd;
    logic [OW-1:0]            oOwner;
    logic                     oLocked;

    modport master (
        output iReq, iClr, iLock, iDat,
        input  oAck, oDat, oUpd, oOwner, oLocked
    );

    modport slave (
        input  iReq, iClr, iLock, iDat,
        output oAck, oDat, oUpd, oOwner, oLocked
    );
endinterface

// File: rtl/zion_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// zion_shared_reg_arbiter
//   Round-robin write arbiter in front of one shared register. Each requester
//   may write (iReq) or clear (iClr, wins over write) the register; a granted
//   requester can hold ownership for a short atomic burst (iLock), limited to
//   LOCK_MAX cycles of ownership in total.
//
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : synchronous reset, active high (also forces oAck to 0)
//     bus  : slave modport of zion_shared_reg_arbiter_if
//            iReq/iClr/iLock/iDat in, oAck (combinational one-hot grant),
//            oDat (register), oUpd (update pulse), oOwner (last writer),
//            oLocked (FSM state is LOCKED) out
// -----------------------------------------------------------------------------
module zion_shared_reg_arbiter #(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               LOCK_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    zion_shared_reg_arbiter_if.slave  bus
);
    localparam int  IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int  CW     = 17;
    localparam bit  LOCKEN = (LOCK_MAX > 0);

    generate
        if (NUM_REQ < 2) begin : gBadNumReq
            $error("zion_shared_reg_arbiter: NUM_REQ must be >= 2");
        end
        if (LOCK_MAX >= 65536) begin : gBadLockMax
            $error("zion_shared_reg_arbiter: LOCK_MAX must be < 2**16");
        end
        if (WIDTH < 1) begin : gBadWidth
            $error("zion_shared_reg_arbiter: WIDTH must be >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      lockOwn;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dat;
    logic               upd;
    logic [IW-1:0]      owner;

    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [IW-1:0]      win;
    int                 scanIdx;
    logic               gnt;
    logic [IW-1:0]      gIdx;
    logic [NUM_REQ-1:0] ack;
    logic [CW-1:0]      cntNext;
    logic               lastCycle;

    assign cand = bus.iReq | bus.iClr;

    // First candidate at or after ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        scanIdx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = (int'(ptr) + k) % NUM_REQ;
            if (!found && cand[scanIdx[IW-1:0]]) begin
                found = 1'b1;
                win   = scanIdx[IW-1:0];
            end
        end
    end

    // While locked only the lock owner can be granted; reset blocks all grants.
    always_comb begin
        gIdx = win;
        gnt  = found;
        if (state == LOCKED) begin
            gIdx = lockOwn;
            gnt  = cand[lockOwn];
        end
        if (rst) begin
            gnt = 1'b0;
        end
        ack = '0;
        if (gnt) begin
            ack[gIdx] = 1'b1;
        end
    end

    // cnt holds the ownership cycles already used, the locking grant being
    // the first. The current LOCKED cycle is number cnt+1 and is the last
    // one allowed once that reaches LOCK_MAX.
    assign cntNext   = cnt + 1'b1;
    assign lastCycle = (cntNext >= CW'(LOCK_MAX));

    function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] idx);
        return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lockOwn <= '0;
            cnt     <= '0;
            dat     <= INI_DATA;
            upd     <= 1'b0;
            owner   <= '0;
        end else begin
            upd <= gnt;
            if (gnt) begin
                dat   <= bus.iClr[gIdx] ? INI_DATA : bus.iDat[int'(gIdx)*WIDTH +: WIDTH];
                owner <= gIdx;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        if (LOCKEN && bus.iLock[win]) begin
                            state   <= LOCKED;
                            lockOwn <= win;
                            cnt     <= CW'(1);
                        end else begin
                            ptr <= nextIdx(win);
                        end
                    end
                end
                LOCKED: begin
                    cnt <= cntNext;
                    if (!bus.iLock[lockOwn] || lastCycle) begin
                        state <= IDLE;
                        ptr   <= nextIdx(lockOwn);
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oAck    = ack;
    assign bus.oDat    = dat;
    assign bus.oUpd    = upd;
    assign bus.oOwner  = owner;
    assign bus.oLocked = (state == LOCKED);
endmodule

// File: tb/tb_zion_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zion_shared_reg_arbiter
//   Two arbiters share the same stimulus: dut_a with LOCK_MAX=3 and dut_b with
//   LOCK_MAX=0. A vector table gives explicit expectations for dut_a; a
//   reference model (ptr, lock owner, ownership cycles used) checks both DUTs
//   on every cycle, including a randomized phase.
// -----------------------------------------------------------------------------
module tb_zion_shared_reg_arbiter;
    localparam int         N   = 4;
    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'hC3;
    localparam logic [31:0] D  = 32'h0D0C0B0A;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus globals ----------------
    logic [N-1:0]   req  = '0;
    logic [N-1:0]   clr  = '0;
    logic [N-1:0]   lck  = '0;
    logic [N*W-1:0] datp = '0;

    int checks = 0;
    int errors = 0;

    zion_shared_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_a ();
    zion_shared_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_b ();

    assign bus_a.iReq  = req;
    assign bus_a.iClr  = clr;
    assign bus_a.iLock = lck;
    assign bus_a.iDat  = datp;
    assign bus_b.iReq  = req;
    assign bus_b.iClr  = clr;
    assign bus_b.iLock = lck;
    assign bus_b.iDat  = datp;

    zion_shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(INI), .LOCK_MAX(3)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    zion_shared_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(INI), .LOCK_MAX(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // ---------------- reference model ----------------
    int         m_lm     [2] = '{3, 0};
    int         m_ptr    [2];
    int         m_locked [2];
    int         m_own    [2];
    int         m_used   [2];
    logic [7:0] m_dat    [2];
    int         m_upd    [2];
    int         m_owner  [2];

    function automatic bit bit_of(logic [N-1:0] v, int i);
        return ((v >> i) & 4'b0001) != 4'b0000;
    endfunction

    function automatic logic [N-1:0] model_ack(int m);
        logic [N-1:0] cand;
        cand = req | clr;
        if (rst) return '0;
        if (m_locked[m] != 0) return bit_of(cand, m_own[m]) ? 4'(1 << m_own[m]) : 4'b0000;
        for (int k = 0; k < N; k++) begin
            if (bit_of(cand, (m_ptr[m] + k) % N)) return 4'(1 << ((m_ptr[m] + k) % N));
        end
        return '0;
    endfunction

    task automatic model_step(int m);
        logic [N-1:0] a;
        int w;
        if (rst) begin
            m_dat[m] = INI; m_upd[m] = 0; m_owner[m] = 0;
            m_ptr[m] = 0; m_locked[m] = 0; m_used[m] = 0;
            return;
        end
        a = model_ack(m);
        w = 0;
        for (int k = 0; k < N; k++) if (bit_of(a, k)) w = k;
        m_upd[m] = (a != 0) ? 1 : 0;
        if (a != 0) begin
            m_dat[m]   = bit_of(clr, w) ? INI : datp[w*W +: W];
            m_owner[m] = w;
        end
        if (m_locked[m] != 0) begin
            m_used[m]++;
            if (!bit_of(lck, m_own[m]) || m_used[m] >= m_lm[m]) begin
                m_locked[m] = 0;
                m_ptr[m]    = (m_own[m] + 1) % N;
            end
        end else if (a != 0) begin
            if (m_lm[m] > 0 && bit_of(lck, w)) begin
                m_locked[m] = 1; m_own[m] = w; m_used[m] = 1;
            end else begin
                m_ptr[m] = (w + 1) % N;
            end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [N-1:0] ack_a_s, ack_b_s;

    // Inputs are already applied (posedge+1). Checks oAck mid-cycle, steps
    // the model at the edge and checks the registered outputs after it.
    task automatic tick();
        #2;
        ack_a_s = bus_a.oAck;
        ack_b_s = bus_b.oAck;
        chk("model_ack_a", 32'(ack_a_s), 32'(model_ack(0)));
        chk("model_ack_b", 32'(ack_b_s), 32'(model_ack(1)));
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("model_dat_a",    32'(bus_a.oDat),    32'(m_dat[0]));
        chk("model_upd_a",    32'(bus_a.oUpd),    32'(m_upd[0]));
        chk("model_owner_a",  32'(bus_a.oOwner),  32'(m_owner[0]));
        chk("model_locked_a", 32'(bus_a.oLocked), 32'(m_locked[0]));
        chk("model_dat_b",    32'(bus_b.oDat),    32'(m_dat[1]));
        chk("model_upd_b",    32'(bus_b.oUpd),    32'(m_upd[1]));
        chk("model_owner_b",  32'(bus_b.oOwner),  32'(m_owner[1]));
        chk("model_locked_b", 32'(bus_b.oLocked), 32'(m_locked[1]));
    endtask

    // ---------------- vector table (expectations for dut_a) ----------------
    typedef struct {
        logic         rst;
        logic [N-1:0] req, clr, lck;
        logic [31:0]  datp;
        logic [N-1:0] ack;
        logic [7:0]   dat;
        logic         upd;
        logic [1:0]   owner;
        logic         locked;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic r, logic [3:0] q, logic [3:0] c, logic [3:0] l, logic [31:0] d,
                       logic [3:0] a, logic [7:0] o, logic u, logic [1:0] ow, logic lk);
        vec_t v;
        v.rst = r; v.req = q; v.clr = c; v.lck = l; v.datp = d;
        v.ack = a; v.dat = o; v.upd = u; v.owner = ow; v.locked = lk;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset with all requesting
        add(1, 4'hF, 0, 0, D, 4'h0, INI, 0, 0, 0);
        add(1, 4'hF, 0, 0, D, 4'h0, INI, 0, 0, 0);
        // round robin
        add(0, 4'hF, 0, 0, D, 4'h1, 8'h0A, 1, 0, 0);
        add(0, 4'hF, 0, 0, D, 4'h2, 8'h0B, 1, 1, 0);
        add(0, 4'hF, 0, 0, D, 4'h4, 8'h0C, 1, 2, 0);
        add(0, 4'hF, 0, 0, D, 4'h8, 8'h0D, 1, 3, 0);
        add(0, 4'hF, 0, 0, D, 4'h1, 8'h0A, 1, 0, 0);
        // clear beats write
        add(0, 4'h1, 0,    0, 32'h0D0C0B55, 4'h1, 8'h55, 1, 0, 0);
        add(0, 4'h2, 4'h2, 0, 32'h0D0CAA55, 4'h2, INI,   1, 1, 0);
        add(0, 4'h0, 0,    0, D,            4'h0, INI,   0, 1, 0);
        // req2 locks with LOCK_MAX=3, req0 also requesting; then req0 next
        add(0, 4'h5, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 1);
        add(0, 4'h5, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 1);
        add(0, 4'h5, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 0);
        add(0, 4'h5, 0, 4'h4, D, 4'h1, 8'h0A, 1, 0, 0);
        // same again with req3 requesting: req3 follows the lock
        add(0, 4'hD, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 1);
        add(0, 4'hD, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 1);
        add(0, 4'hD, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 0);
        add(0, 4'hD, 0, 4'h0, D, 4'h8, 8'h0D, 1, 3, 0);
        // early unlock: final ack honoured, ptr lands on 2
        add(0, 4'h2, 0, 4'h2, D, 4'h2, 8'h0B, 1, 1, 1);
        add(0, 4'hF, 0, 4'h0, D, 4'h2, 8'h0B, 1, 1, 0);
        add(0, 4'hF, 0, 4'h0, D, 4'h4, 8'h0C, 1, 2, 0);
        // reset mid-lock: order restarts at req0
        add(0, 4'h2, 0, 4'h2, D, 4'h2, 8'h0B, 1, 1, 1);
        add(1, 4'hF, 0, 4'h2, D, 4'h0, INI,   0, 0, 0);
        add(0, 4'hF, 0, 4'h0, D, 4'h1, 8'h0A, 1, 0, 0);
        add(0, 4'hF, 0, 4'h0, D, 4'h2, 8'h0B, 1, 1, 0);
        // lock owner idle: others stall, count still runs out
        add(0, 4'h4, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 1);
        add(0, 4'hB, 0, 4'h4, D, 4'h0, 8'h0C, 0, 2, 1);
        add(0, 4'h4, 0, 4'h4, D, 4'h4, 8'h0C, 1, 2, 0);
        add(0, 4'hF, 0, 4'h0, D, 4'h8, 8'h0D, 1, 3, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; clr = vecs[i].clr;
            lck = vecs[i].lck; datp = vecs[i].datp;
            tick();
            chk($sformatf("vec%0d_ack", i),    32'(ack_a_s),         32'(vecs[i].ack));
            chk($sformatf("vec%0d_dat", i),    32'(bus_a.oDat),      32'(vecs[i].dat));
            chk($sformatf("vec%0d_upd", i),    32'(bus_a.oUpd),      32'(vecs[i].upd));
            chk($sformatf("vec%0d_owner", i),  32'(bus_a.oOwner),    32'(vecs[i].owner));
            chk($sformatf("vec%0d_locked", i), 32'(bus_a.oLocked),   32'(vecs[i].locked));
        end

        // LOCK_MAX=0 (dut_b): iLock all ones is ignored, plain round robin
        rst = 1; req = 4'hF; clr = 0; lck = 4'hF; datp = D;
        tick();
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("nolock_ack%0d", k), 32'(ack_b_s), 32'(1 << (k % 4)));
            chk($sformatf("nolock_dat%0d", k), 32'(bus_b.oDat), 32'(8'h0A + 8'(k % 4)));
            chk($sformatf("nolock_locked%0d", k), 32'(bus_b.oLocked), 32'(0));
        end

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req  = 4'($urandom_range(0, 15));
            clr  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            lck  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            datp = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
